// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store unit controller.
//   - Shared defines: `WORD_WIDTH (data/address width) and the access size
//     encodings `LSU_SIZE_B / `LSU_SIZE_H / `LSU_SIZE_W. They live here, in
//     the file compiled first, so every other file sees one definition.
//   - lsu_state_e: controller FSM states.
//   - is_misaligned / align_low: size-dependent alignment helpers.
// Optional feature macro used by lsu_ctrl: LSU_MISALIGN_TRAP_EN.

`ifndef LSU_DEFINES_DONE
`define LSU_DEFINES_DONE
`define WORD_WIDTH 32
`define LSU_SIZE_B 2'd0
`define LSU_SIZE_H 2'd1
`define LSU_SIZE_W 2'd2
`endif

package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr
    } lsu_state_e;

    // Reserved size 3 behaves like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            `LSU_SIZE_B: return 1'b0;
            `LSU_SIZE_H: return lo[0];
            default:     return |lo;
        endcase
    endfunction

    // Drop the address bits below the access size.
    function automatic logic [1:0] align_low(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            `LSU_SIZE_B: return lo;
            `LSU_SIZE_H: return {lo[1], 1'b0};
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   Loads : pick the byte/half lane out of the read word and sign- or
//           zero-extend it into load_data.
//   Stores: merge the right-justified byte/half of wdata into its lane of
//           rdata, giving the full word to write back in merged.
// Ports:
//   size        in  2  access size (0 byte, 1 half, 2/3 word)
//   is_unsigned in  1  zero-extend loads
//   lane        in  2  address low bits (little-endian lane select)
//   rdata       in  W  word read from memory
//   wdata       in  W  store data, right-justified
//   load_data   out W  extended load result
//   merged      out W  read word with the store lane replaced

module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned W = `WORD_WIDTH
) (
    input  logic [1:0]   size,
    input  logic         is_unsigned,
    input  logic [1:0]   lane,
    input  logic [W-1:0] rdata,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] load_data,
    output logic [W-1:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = 8'h00;
        half_v    = 16'h0000;
        load_data = rdata;
        merged    = rdata;
        case (size)
            `LSU_SIZE_B: begin
                byte_v    = rdata[{lane, 3'b000} +: 8];
                load_data = {{(W-8){~is_unsigned & byte_v[7]}}, byte_v};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            `LSU_SIZE_H: begin
                half_v    = rdata[{lane[1], 4'b0000} +: 16];
                load_data = {{(W-16){~is_unsigned & half_v[15]}}, half_v};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit controller toward a word-wide data
// memory with combinational reads and posedge-committed writes.
//   Loads take 2 cycles (accept, read, respond); word stores 2 cycles;
//   byte/half stores use read-modify-write and take 3 cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/we/size/unsigned/addr/wdata   request (sampled in idle only)
//   busy                     high while a request is in flight
//   resp_valid, resp_data    completion pulse and extended load result
//   addr_err                 misalignment pulse (trap build only, else 0)
//   mem_read_en/addr/data    word read port (data combinational)
//   mem_write_en/addr/data   word write port
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned requests
// with an addr_err pulse; otherwise the address is truncated to the size.

module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         busy,
    output logic         resp_valid,
    output logic [W-1:0] resp_data,
    output logic         addr_err,
    output logic         mem_read_en,
    output logic [W-1:0] mem_read_addr,
    input  logic [W-1:0] mem_read_data,
    output logic         mem_write_en,
    output logic [W-1:0] mem_write_addr,
    output logic [W-1:0] mem_write_data
);

    lsu_state_e   state_q, state_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [W-1:0] addr_q, addr_d;
    // Holds the store data, then the merged word during read-modify-write.
    logic [W-1:0] data_q, data_d;
    logic         resp_valid_q, resp_valid_d;
    logic [W-1:0] resp_data_q, resp_data_d;
    logic         trap;
    logic [W-1:0] load_data;
    logic [W-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic addr_err_q, addr_err_d;
    assign trap     = is_misaligned(req_size, req_addr[1:0]);
    assign addr_err = addr_err_q;
`else
    assign trap     = 1'b0;
    assign addr_err = 1'b0;
`endif

    lsu_align #(
        .W(W)
    ) u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .rdata       (mem_read_data),
        .wdata       (data_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        addr_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid && trap) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_err_d = 1'b1;
`endif
                end else if (req_valid) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    addr_d = {req_addr[W-1:2], align_low(req_size, req_addr[1:0])};
                    data_d = req_wdata;
                    if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_size == `LSU_SIZE_B || req_size == `LSU_SIZE_H) begin
                        state_d = StRmwRd;
                    end else begin
                        state_d = StStore;
                    end
                end
            end
            StLoad: begin
                resp_data_d  = load_data;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StStore: begin
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StRmwRd: begin
                data_d  = merged;
                state_d = StRmwWr;
            end
            StRmwWr: begin
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            addr_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            addr_err_q   <= addr_err_d;
`endif
        end
    end

    assign busy           = (state_q != StIdle);
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign mem_read_en    = (state_q == StLoad) || (state_q == StRmwRd);
    assign mem_read_addr  = {addr_q[W-1:2], 2'b00};
    // Reset in a write cycle abandons the request before memory commits it.
    assign mem_write_en   = ((state_q == StStore) || (state_q == StRmwWr)) && !rst;
    assign mem_write_addr = {addr_q[W-1:2], 2'b00};
    assign mem_write_data = data_q;

endmodule
